// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions: axis phase encoding, default 640x480@60 constants
// and the helper that sums one axis's segments into its total period.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CW       = 10;

    function automatic int unsigned vga_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Outputs are the next-state values so the parent can register them with zero skew.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned CW     = DEF_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_Step,
    output logic [CW-1:0] o_Count,
    output phase_e        o_Phase,
    output logic          o_Wrap,
    output logic          o_Sync_Raw
);

    localparam int unsigned TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CW-1:0] LAST_ACT  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] LAST_FP   = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] LAST_SYNC = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST_TOT  = CW'(TOTAL - 1);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segments
        $error("vga_axis_timer: every active/porch/sync segment must be at least 1");
    end
    if (64'(TOTAL) > (64'd1 << CW)) begin : g_bad_width
        $error("vga_axis_timer: CW too narrow for TOTAL-1");
    end

    logic [CW-1:0] r_Count;
    phase_e        r_Phase;
    logic [CW-1:0] w_Count_Next;
    phase_e        w_Phase_Next;
    logic          w_Wrap;

    // Next-state decode; holds everything when not stepped.
    always_comb begin
        w_Count_Next = r_Count;
        w_Phase_Next = r_Phase;
        w_Wrap       = 1'b0;
        if (i_Step) begin
            if (r_Count == LAST_TOT) begin
                w_Count_Next = '0;
                w_Wrap       = 1'b1;
            end else begin
                w_Count_Next = r_Count + CW'(1);
            end
            case (r_Phase)
                PH_ACTIVE: if (r_Count == LAST_ACT)  w_Phase_Next = PH_FRONT;
                PH_FRONT:  if (r_Count == LAST_FP)   w_Phase_Next = PH_SYNC;
                PH_SYNC:   if (r_Count == LAST_SYNC) w_Phase_Next = PH_BACK;
                PH_BACK:   if (r_Count == LAST_TOT)  w_Phase_Next = PH_ACTIVE;
                default:   w_Phase_Next = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_Count <= '0;
            r_Phase <= PH_ACTIVE;
        end else begin
            r_Count <= w_Count_Next;
            r_Phase <= w_Phase_Next;
        end
    end

    assign o_Count    = w_Count_Next;
    assign o_Phase    = w_Phase_Next;
    assign o_Wrap     = w_Wrap;
    assign o_Sync_Raw = (w_Phase_Next == PH_SYNC);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: horizontal/vertical axis timers advanced by the pixel tick,
// with registered sync, active-video, coordinate and line/frame start outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_Pixel_Tick,
    output logic          o_HSync,
    output logic          o_VSync,
    output logic          o_Active,
    output logic [CW-1:0] o_X,
    output logic [CW-1:0] o_Y,
    output logic          o_Line_Start,
    output logic          o_Frame_Start
);

    logic [CW-1:0] w_H_Count;
    logic [CW-1:0] w_V_Count;
    phase_e        w_H_Phase;
    phase_e        w_V_Phase;
    logic          w_H_Wrap;
    logic          w_V_Wrap;
    logic          w_H_Sync;
    logic          w_V_Sync;
    logic          w_V_Step;

    // Vertical axis only moves on the tick that ends a line.
    assign w_V_Step = i_Pixel_Tick & w_H_Wrap;

    vga_axis_timer #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clock      (clock),
        .reset      (reset),
        .i_Step     (i_Pixel_Tick),
        .o_Count    (w_H_Count),
        .o_Phase    (w_H_Phase),
        .o_Wrap     (w_H_Wrap),
        .o_Sync_Raw (w_H_Sync)
    );

    vga_axis_timer #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clock      (clock),
        .reset      (reset),
        .i_Step     (w_V_Step),
        .o_Count    (w_V_Count),
        .o_Phase    (w_V_Phase),
        .o_Wrap     (w_V_Wrap),
        .o_Sync_Raw (w_V_Sync)
    );

    // Output register stage, fed from the axis next-state values.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_X           <= '0;
            o_Y           <= '0;
            o_Active      <= 1'b1;
            o_HSync       <= ~SYNC_POL;
            o_VSync       <= ~SYNC_POL;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_X           <= w_H_Count;
            o_Y           <= w_V_Count;
            o_Active      <= (w_H_Phase == PH_ACTIVE) && (w_V_Phase == PH_ACTIVE);
            o_HSync       <= w_H_Sync ? SYNC_POL : ~SYNC_POL;
            o_VSync       <= w_V_Sync ? SYNC_POL : ~SYNC_POL;
            o_Line_Start  <= w_H_Wrap;
            o_Frame_Start <= w_H_Wrap & w_V_Wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: full horizontal timing, shortened vertical
// timing (6/2/2/2 lines) so that whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 6;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int unsigned CW       = 10;
    localparam int HT    = 800;
    localparam int VT    = 12;
    localparam int FRAME = HT * VT;
    localparam int HS0   = 656;
    localparam int HS1   = 751;
    localparam int VS0   = 8;
    localparam int VS1   = 9;

    logic          clock;
    logic          reset;
    logic          i_Pixel_Tick;
    logic          o_HSync;
    logic          o_VSync;
    logic          o_Active;
    logic [CW-1:0] o_X;
    logic [CW-1:0] o_Y;
    logic          o_Line_Start;
    logic          o_Frame_Start;

    int n_checks = 0;
    int n_fail   = 0;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (1'b0), .CW (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_Pixel_Tick  (i_Pixel_Tick),
        .o_HSync       (o_HSync),
        .o_VSync       (o_VSync),
        .o_Active      (o_Active),
        .o_X           (o_X),
        .o_Y           (o_Y),
        .o_Line_Start  (o_Line_Start),
        .o_Frame_Start (o_Frame_Start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic rst;
        logic tick;
        int   x;
        int   y;
        logic act;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic cyc(input logic t, input logic r);
        i_Pixel_Tick = t;
        reset        = r;
        @(posedge clock);
        #1;
    endtask

    // Tick until the outputs show (tx,ty); stop without stepping past it.
    task automatic run_to(input int tx, input int ty);
        int n = 0;
        while (!(int'(o_X) == tx && int'(o_Y) == ty) && n < FRAME + 10) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk($sformatf("reach_%0d_%0d", tx, ty), int'(int'(o_X) == tx && int'(o_Y) == ty), 1);
    endtask

    task automatic chk_all(input string nm, input int x, input int y, input logic act,
                           input logic hs, input logic vs, input logic ls, input logic fs);
        chk({nm, "_x"},  int'(o_X), x);
        chk({nm, "_y"},  int'(o_Y), y);
        chk({nm, "_act"}, int'(o_Active), int'(act));
        chk({nm, "_hs"}, int'(o_HSync), int'(hs));
        chk({nm, "_vs"}, int'(o_VSync), int'(vs));
        chk({nm, "_ls"}, int'(o_Line_Start), int'(ls));
        chk({nm, "_fs"}, int'(o_Frame_Start), int'(fs));
    endtask

    initial begin
        int   mx, my, n;
        logic t, els, efs, eact, ehs, evs;

        reset        = 1'b1;
        i_Pixel_Tick = 1'b0;

        // Reset held with tick high, then tick gating 1,0,0,1, then reset with tick low.
        vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].tick, vecs[i].rst);
            chk_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].act,
                    vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs);
        end

        // Active drop and HSync edges on line 0.
        run_to(639, 0);
        chk("act_639", int'(o_Active), 1);
        cyc(1'b1, 1'b0);
        chk_all("x640", 640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_to(655, 0);
        chk("hs_655", int'(o_HSync), 1);
        cyc(1'b1, 1'b0);
        chk_all("x656", 656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to(751, 0);
        chk("hs_751", int'(o_HSync), 0);
        cyc(1'b1, 1'b0);
        chk_all("x752", 752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Line wrap at Y=10, strobe exactly one clock.
        run_to(799, 10);
        cyc(1'b1, 1'b0);
        chk_all("lwrap", 0, 11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk_all("lwrap_next", 1, 11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Frame wrap: both strobes together, back to active video.
        run_to(799, VT - 1);
        cyc(1'b1, 1'b0);
        chk_all("fwrap", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk_all("fwrap_next", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Mid-frame reset, then frame period between Frame_Start pulses.
        run_to(300, 5);
        cyc(1'b1, 1'b1);
        chk_all("midrst", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!o_Frame_Start && n < FRAME + 10) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk("first_fs_after_rst", n, FRAME);
        n = 0;
        do begin
            cyc(1'b1, 1'b0);
            n++;
        end while (!o_Frame_Start && n < FRAME + 10);
        chk("frame_period", n, FRAME);

        // Gated random-tick run against a reference raster model.
        cyc(1'b0, 1'b1);
        chk_all("rst2", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mx = 0;
        my = 0;
        for (int k = 0; k < 12000; k++) begin
            t = ($urandom_range(0, 7) != 0);
            cyc(t, 1'b0);
            els = 1'b0;
            efs = 1'b0;
            if (t) begin
                els = (mx == HT - 1);
                efs = els && (my == VT - 1);
                if (els) begin
                    mx = 0;
                    my = efs ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
            eact = (mx < int'(H_ACTIVE)) && (my < int'(V_ACTIVE));
            ehs  = !(mx >= HS0 && mx <= HS1);
            evs  = !(my >= VS0 && my <= VS1);
            chk_all("model", mx, my, eact, ehs, evs, els, efs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the attitude-indicator display path. It consumes the one-clock pixel-tick enable produced by the upstream modulo-N prescaler counter and advances horizontal and vertical position counters on each tick. From those counters it produces registered HSYNC/VSYNC, an active-video flag, pixel coordinates, and line/frame start strobes for the horizon-rendering stage downstream.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted sync level (0 = active-low)
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clock  in  1  system clock; one clock domain; the only clock in the block
- reset  in  1  synchronous, active-high reset
- i_Pixel_Tick  in  1  advance enable from the prescaler; may be held high continuously
- o_HSync  out  1  horizontal sync at SYNC_POL while asserted
- o_VSync  out  1  vertical sync at SYNC_POL while asserted
- o_Active  out  1  high when h < H_ACTIVE and v < V_ACTIVE
- o_X  out  CW  raw horizontal count, 0..H_TOTAL-1
- o_Y  out  CW  raw vertical count, 0..V_TOTAL-1
- o_Line_Start  out  1  one-clock strobe on entry to h = 0
- o_Frame_Start  out  1  one-clock strobe on entry to (0,0)

## Operation
- Definitions: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- Each axis runs a phase FSM with states ACTIVE, FRONT, SYNC, BACK, plus a position counter.
  - The FSM moves to the next phase when the counter reaches that phase's last value.
  - BACK returns to ACTIVE on wrap.
- The horizontal axis steps on every clock with i_Pixel_Tick = 1.
- The vertical axis steps only on a tick that wraps h from H_TOTAL-1 to 0.
- Wrap rules:
  - h = H_TOTAL-1 with tick: h -> 0, o_Line_Start pulses.
  - If v = V_TOTAL-1 at the same time: v -> 0, o_Frame_Start also pulses. Both strobes are high in the same cycle.
- Sync windows:
  - HSync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - VSync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - Outside these windows each sync output is at ~SYNC_POL.
- When i_Pixel_Tick = 0, all counters, FSMs and level outputs hold, and both strobes are 0.
- Reset has priority over tick. On reset:
  - h = 0, v = 0, both FSMs in ACTIVE.
  - o_X = 0, o_Y = 0, o_Active = 1.
  - o_HSync = o_VSync = ~SYNC_POL.
  - o_Line_Start = o_Frame_Start = 0.
- Reset applied mid-frame returns the block to (0,0) on the next edge. No strobe is generated by reset.
- The first tick after reset moves the position to (1,0).

## Timing
- Every output is a register updated on the same edge as the counters, decoded from the next-state values.
- There is zero cycles of skew between o_X/o_Y and o_HSync/o_VSync/o_Active. There is no combinational path from input to output.
- Latency is one clock from a sampled i_Pixel_Tick to the updated outputs.
- Strobes are exactly one clock wide, even when i_Pixel_Tick is held high.
- With a continuous tick:
  - line period = H_TOTAL clocks;
  - frame period = H_TOTAL × V_TOTAL clocks (420000).
- Parameter constraints: each porch and sync value ≥ 1. Violating this is a configuration error, checked by an elaboration-time assertion.

## Structure
- Shared package vga_timing_pkg holds:
  - phase enum: ACTIVE, FRONT, SYNC, BACK;
  - default 640×480@60 timing constants;
  - a function computing total = active + fp + sync + bp.
- Sub-module vga_axis_timer (parameters ACTIVE, FP, SYNC, BP, CW).
  - Inputs: i_Step. Outputs: o_Count, o_Phase, o_Wrap, o_Sync_Raw.
  - It is instantiated twice:
    - horizontal instance stepped by i_Pixel_Tick;
    - vertical instance stepped by i_Pixel_Tick & horizontal o_Wrap.
- The top level registers the outputs, applies SYNC_POL, and generates the strobes.

## Test plan
- Reset: hold reset 3 clocks with tick high. Then X=0, Y=0, Active=1, HSync=VSync=1, and both strobes 0. The first tick gives X=1.
- Hsync edges, continuous tick:
  - HSync goes 0 on the edge where X becomes 656;
  - it returns to 1 where X becomes 752;
  - Active drops where X becomes 640.
- Tick gating: tick pattern 1,0,0,1 from reset gives X = 1,1,1,2, with no strobes.
- Line wrap: with X=799, Y=10, a tick gives X=0, Y=11, Line_Start=1 for one clock, Frame_Start=0.
- Frame wrap: with X=799, Y=524, a tick gives (0,0), both strobes high for one clock, and Active=1. VSync is low only for Y in 490..491.
- Mid-frame reset: at X=300, Y=200, assert reset for 1 clock with tick high. Next cycle X=0, Y=0, no strobe. Run one full frame and confirm 420000 clocks between Frame_Start pulses.
